// File: rtl/button_debounce_if.sv
// Button-side signal bundle for button_debounce: raw button in, debounced level and strobes out.
// master drives the raw button; slave is the debouncer itself.
interface button_debounce_if;
   logic btn_in;
   logic btn_level;
   logic press_pulse;
   logic release_pulse;
   logic long_press_pulse;

   modport master (
      output btn_in,
      input  btn_level,
      input  press_pulse,
      input  release_pulse,
      input  long_press_pulse
   );

   modport slave (
      input  btn_in,
      output btn_level,
      output press_pulse,
      output release_pulse,
      output long_press_pulse
   );
endinterface

// File: rtl/button_debounce.sv
// Push-button debouncer: 2-flop synchronizer, 4-state FSM, registered level and press/release strobes.
// Define BUTTON_DEBOUNCE_LONG_PRESS_EN to enable the long_press_pulse hold timer.
module button_debounce #(
   parameter int unsigned CLK_FREQ      = 32'd125000000,
   parameter int unsigned DEBOUNCE_MS   = 32'd10,
   parameter int unsigned LONG_PRESS_MS = 32'd1000
) (
   input  logic               clk,
   input  logic               reset,
   button_debounce_if.slave   bus,
   output logic [1:0]         dbg_state
);

   localparam int unsigned DB_RAW    = (CLK_FREQ / 32'd1000) * DEBOUNCE_MS;
   localparam int unsigned DB_CYCLES = (DB_RAW == 32'd0) ? 32'd1 : DB_RAW;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_PRESS   = 2'd1,
      PRESSED      = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_t;

   state_t      state, state_n;
   logic [31:0] db_count, db_count_n;
   logic        sync_1, btn_sync;
   logic        btn_level_r, btn_level_n;
   logic        press_r, press_n;
   logic        release_r, release_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_1   <= 1'b0;
         btn_sync <= 1'b0;
      end else begin
         sync_1   <= bus.btn_in;
         btn_sync <= sync_1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         db_count    <= 32'd0;
         btn_level_r <= 1'b0;
         press_r     <= 1'b0;
         release_r   <= 1'b0;
      end else begin
         state       <= state_n;
         db_count    <= db_count_n;
         btn_level_r <= btn_level_n;
         press_r     <= press_n;
         release_r   <= release_n;
      end
   end

   // db_count is entered at 1 and only advances while below DB_CYCLES, so it cannot wrap.
   always_comb begin
      state_n     = state;
      db_count_n  = db_count;
      btn_level_n = btn_level_r;
      press_n     = 1'b0;
      release_n   = 1'b0;
      case (state)
         IDLE: begin
            if (btn_sync) begin
               state_n    = WAIT_PRESS;
               db_count_n = 32'd1;
            end else begin
               db_count_n = 32'd0;
            end
         end
         WAIT_PRESS: begin
            if (!btn_sync) begin
               state_n    = IDLE;
               db_count_n = 32'd0;
            end else if (db_count == DB_CYCLES) begin
               state_n     = PRESSED;
               db_count_n  = 32'd0;
               btn_level_n = 1'b1;
               press_n     = 1'b1;
            end else begin
               db_count_n = db_count + 32'd1;
            end
         end
         PRESSED: begin
            if (!btn_sync) begin
               state_n    = WAIT_RELEASE;
               db_count_n = 32'd1;
            end else begin
               db_count_n = 32'd0;
            end
         end
         WAIT_RELEASE: begin
            if (btn_sync) begin
               state_n    = PRESSED;
               db_count_n = 32'd0;
            end else if (db_count == DB_CYCLES) begin
               state_n     = IDLE;
               db_count_n  = 32'd0;
               btn_level_n = 1'b0;
               release_n   = 1'b1;
            end else begin
               db_count_n = db_count + 32'd1;
            end
         end
         default: begin
            state_n    = IDLE;
            db_count_n = 32'd0;
         end
      endcase
   end

   assign bus.btn_level     = btn_level_r;
   assign bus.press_pulse   = press_r;
   assign bus.release_pulse = release_r;
   assign dbg_state         = state;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
   localparam int unsigned LP_CYCLES = (CLK_FREQ / 32'd1000) * LONG_PRESS_MS;

   logic [31:0] lp_count;
   logic        long_r;

   // A release landing on the same edge as the hold expiry wins: no long strobe for that press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lp_count <= 32'd0;
         long_r   <= 1'b0;
      end else begin
         long_r <= 1'b0;
         if (press_n) begin
            lp_count <= 32'd0;
         end else if ((state == PRESSED || state == WAIT_RELEASE) && lp_count != LP_CYCLES) begin
            lp_count <= lp_count + 32'd1;
            if ((lp_count + 32'd1) == LP_CYCLES && !release_n) begin
               long_r <= 1'b1;
            end
         end
      end
   end

   assign bus.long_press_pulse = long_r;
`else
   assign bus.long_press_pulse = 1'b0;
`endif

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 125000000, giving the clk frequency in Hz (32-bit).
REQ-002 SHALL have parameter DEBOUNCE_MS, default 10, giving the stable-input time in ms before a level change is accepted.
REQ-003 SHALL have parameter LONG_PRESS_MS, default 1000, giving the hold time in ms before long_press_pulse fires.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 btn_in  input  1  raw push-button, asynchronous to clk, bouncing, active-high.
REQ-007 btn_level  output  1  debounced button level, 1 = pressed.
REQ-008 press_pulse  output  1  one-cycle strobe on each accepted press.
REQ-009 release_pulse  output  1  one-cycle strobe on each accepted release.
REQ-010 long_press_pulse  output  1  one-cycle strobe when a press has been held LONG_PRESS_MS.

Function
REQ-011 SHALL derive DB_CYCLES = (CLK_FREQ/1000)*DEBOUNCE_MS and LP_CYCLES = (CLK_FREQ/1000)*LONG_PRESS_MS, both 32-bit unsigned; DB_CYCLES SHALL be at least 1.
REQ-012 SHALL pass btn_in through a two-flop synchronizer; only the second flop output (btn_sync) drives the logic.
REQ-013 SHALL implement FSM states IDLE (released), WAIT_PRESS, PRESSED, WAIT_RELEASE.
REQ-014 From IDLE, btn_sync=1 SHALL go to WAIT_PRESS with db_count=1; otherwise the FSM stays in IDLE with db_count=0.
REQ-015 In WAIT_PRESS, btn_sync=0 SHALL return to IDLE with db_count=0 and no pulse (a bounce).
REQ-016 In WAIT_PRESS, btn_sync=1 with db_count=DB_CYCLES SHALL go to PRESSED, set btn_level=1 and assert press_pulse for exactly that cycle; otherwise db_count SHALL increment.
REQ-017 PRESSED to WAIT_RELEASE to IDLE SHALL mirror REQ-014..016 with btn_sync=0 as the qualifying level, clearing btn_level and asserting release_pulse.
REQ-018 Latency: once btn_in is stable, the pulse SHALL follow exactly DB_CYCLES+2 rising edges after the first edge that samples the new level.
REQ-019 All outputs SHALL be registered; press_pulse and release_pulse SHALL never be high in the same cycle.
REQ-020 Any input glitch shorter than DB_CYCLES clk cycles (after synchronization) SHALL produce no output change.
REQ-021 db_count SHALL never exceed DB_CYCLES and SHALL never wrap.

Reset
REQ-022 reset SHALL force FSM=IDLE, synchronizer flops=0, db_count=0, lp_count=0, btn_level=0, and all pulses=0, immediately and independent of clk.
REQ-023 If btn_in is held high through reset deassertion, the block SHALL debounce it as a fresh press (press_pulse after DB_CYCLES+2 edges).
REQ-024 Reset asserted mid-debounce or mid-hold SHALL discard the partial count and emit no pulse.

Configuration
REQ-025 Macro BUTTON_DEBOUNCE_LONG_PRESS_EN: when defined, lp_count SHALL clear on press_pulse and increment each PRESSED or WAIT_RELEASE cycle, saturating at LP_CYCLES.
REQ-026 With the macro defined, long_press_pulse SHALL fire once, for one cycle, when lp_count reaches LP_CYCLES; it SHALL fire at most once per press and never after release_pulse.
REQ-027 With the macro undefined, long_press_pulse SHALL be tied 0, lp_count SHALL not exist, and all other behaviour SHALL be identical.

Verification (CLK_FREQ=1000, DEBOUNCE_MS=4 -> DB_CYCLES=4, LONG_PRESS_MS=10 -> LP_CYCLES=10)
REQ-028 Clean press: btn_in 0->1 held 20 cycles -> press_pulse high for 1 cycle, 6 edges after the first sampling edge; btn_level=1 from that cycle.
REQ-029 Bounce: btn_in 1 for 3 cycles, 0 for 2, 1 for 3, then 0 -> no pulse, btn_level stays 0.
REQ-030 Release: from pressed, btn_in 0 held 10 cycles -> release_pulse for 1 cycle after 6 edges; btn_level=0.
REQ-031 Long press (macro on): hold 30 cycles after press_pulse -> exactly one long_press_pulse, 10 cycles after press_pulse; with the macro off, it stays 0.
REQ-032 Reset mid-operation: assert reset 2 cycles into WAIT_PRESS -> all outputs 0 at once; with btn_in held high, press_pulse 6 edges after reset deasserts.
